// File: rtl/uart_rx_byte_if.sv
// Receive-side output bundle of one UART channel: framed byte, strobes and monitor state.
// master = the receiver that drives it, slave = the byte consumer or monitor.
interface uart_rx_byte_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       rx_busy;
  logic [3:0] state;

  modport master (
    output rx_data,
    output rx_valid,
    output frame_err,
    output rx_busy,
    output state
  );

  modport slave (
    input rx_data,
    input rx_valid,
    input frame_err,
    input rx_busy,
    input state
  );
endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver. It synchronises the rx pin and centre-samples each bit.
// It emits a one-cycle rx_valid strobe per good byte and a one-cycle frame_err strobe per bad stop.
module uart_rx_byte #(
  parameter int unsigned BAUD_DIV = 434
) (
  input  logic           sclk,
  input  logic           srst_n,
  input  logic           rx,
  uart_rx_byte_if.master rx_if
);

  typedef enum logic [3:0] {
    StIdle  = 4'd0,
    StStart = 4'd1,
    StData  = 4'd2,
    StStop  = 4'd3,
    StBrk   = 4'd4
  } state_e;

  localparam logic [15:0] HalfLast = 16'(BAUD_DIV / 2 - 1);
  localparam logic [15:0] BitLast  = 16'(BAUD_DIV - 1);

  state_e      state_q, state_d;
  logic        sync_q, rx_s_q, rx_prev_q;
  logic [15:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        frame_err_q, frame_err_d;

  logic fall, half_hit, bit_hit;

  assign fall     = rx_prev_q & ~rx_s_q;
  assign half_hit = (baud_cnt_q == HalfLast);
  assign bit_hit  = (baud_cnt_q == BitLast);

  // The synchroniser and edge flops reset to the idle level, so no start edge is seen after reset.
  always_ff @(posedge sclk) begin
    if (!srst_n) begin
      sync_q      <= 1'b1;
      rx_s_q      <= 1'b1;
      rx_prev_q   <= 1'b1;
      state_q     <= StIdle;
      baud_cnt_q  <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sync_q      <= rx;
      rx_s_q      <= sync_q;
      rx_prev_q   <= rx_s_q;
      state_q     <= state_d;
      baud_cnt_q  <= baud_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (fall) state_d = StStart;
      StStart: if (half_hit) state_d = rx_s_q ? StIdle : StData;
      StData:  if (bit_hit && (bit_idx_q == 3'd7)) state_d = StStop;
      StStop:  if (bit_hit) state_d = rx_s_q ? StIdle : StBrk;
      StBrk:   if (rx_s_q) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    baud_cnt_d  = baud_cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      StStart: begin
        if (half_hit) begin
          baud_cnt_d = '0;
          bit_idx_d  = '0;
        end else begin
          baud_cnt_d = baud_cnt_q + 16'd1;
        end
      end
      StData: begin
        if (bit_hit) begin
          shift_d    = {rx_s_q, shift_q[7:1]};
          baud_cnt_d = '0;
          if (bit_idx_q != 3'd7) bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          baud_cnt_d = baud_cnt_q + 16'd1;
        end
      end
      StStop: begin
        if (bit_hit) begin
          baud_cnt_d = '0;
          if (rx_s_q) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 16'd1;
        end
      end
      default: baud_cnt_d = '0;
    endcase
  end

  assign rx_if.rx_data   = rx_data_q;
  assign rx_if.rx_valid  = rx_valid_q;
  assign rx_if.frame_err = frame_err_q;
  assign rx_if.rx_busy   = (state_q != StIdle);
  assign rx_if.state     = state_q;

endmodule

// File: tb/tb_uart_rx_byte.sv
// Bench for uart_rx_byte at BAUD_DIV=16. Directed frames push the expected strobes into a
// scoreboard. A negedge monitor pops and compares each strobe, including its arrival cycle.
module tb_uart_rx_byte;

  localparam int unsigned Div = 16;
  // The rx pin needs 3 cycles to reach the edge detector, then 8+9*16 cycles reach the stop sample.
  localparam int StrobeLat = 3 + Div / 2 + 9 * Div;

  typedef struct {
    bit       is_err;
    bit [7:0] data;
    int       cyc;
  } exp_t;

  logic sclk;
  logic srst_n;
  logic rx;

  uart_rx_byte_if u_if ();

  uart_rx_byte #(
    .BAUD_DIV(Div)
  ) u_dut (
    .sclk  (sclk),
    .srst_n(srst_n),
    .rx    (rx),
    .rx_if (u_if)
  );

  int       total = 0;
  int       bad = 0;
  int       cyc = 0;
  exp_t     sb[$];
  int       st_log[$];
  int       last_st = 0;
  bit       prev_strobe = 0;
  bit [7:0] last_good = 8'h00;

  initial sclk = 1'b0;
  always #10 sclk = ~sclk;

  always @(posedge sclk) cyc = cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    total = total + 1;
    if (act != exp) begin
      bad = bad + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge sclk) begin
    exp_t e;
    if (u_if.rx_valid && u_if.frame_err) check("strobes_together", 1, 0);
    if (u_if.rx_valid || u_if.frame_err) begin
      check("strobe_width", int'(prev_strobe), 0);
      if (sb.size() == 0) begin
        check("unexpected_strobe", 1, 0);
      end else begin
        e = sb.pop_front();
        check("strobe_kind_err", int'(u_if.frame_err), int'(e.is_err));
        check("strobe_rx_data", int'(u_if.rx_data), int'(e.data));
        check("strobe_cycle", cyc, e.cyc);
      end
    end
    prev_strobe = u_if.rx_valid || u_if.frame_err;
  end

  always @(negedge sclk) begin
    if (int'(u_if.state) != last_st) begin
      last_st = int'(u_if.state);
      st_log.push_back(last_st);
    end
  end

  // Drives one 8N1 frame. abort_at > 0 pulses reset at that cycle of the frame and stops.
  task automatic drive_frame(input bit [7:0] b, input bit stop, input int abort_at,
                             input bit chk_busy);
    logic [9:0] fr;
    int         start;
    exp_t       e;
    fr = {stop, b, 1'b0};
    start = 0;
    for (int i = 0; i < 10 * Div; i++) begin
      @(posedge sclk);
      #1;
      rx = fr[i / Div];
      if (i == 0) begin
        start = cyc;
        if (abort_at == 0) begin
          e.is_err = !stop;
          e.data   = stop ? b : last_good;
          e.cyc    = start + StrobeLat;
          sb.push_back(e);
          if (stop) last_good = b;
        end
      end
      if (chk_busy) begin
        if (i == 2) check("busy_before_t0", int'(u_if.rx_busy), 0);
        if (i == 3) check("busy_at_t0", int'(u_if.rx_busy), 1);
        if (i == StrobeLat - 1) check("busy_before_stop", int'(u_if.rx_busy), 1);
        if (i == StrobeLat) check("busy_after_stop", int'(u_if.rx_busy), 0);
      end
      if (abort_at != 0 && i == abort_at) begin
        srst_n = 1'b0;
        @(posedge sclk);
        #1;
        srst_n = 1'b1;
        rx = 1'b1;
        last_good = 8'h00;
        check("abort_state", int'(u_if.state), 0);
        check("abort_rx_data", int'(u_if.rx_data), 0);
        check("abort_rx_valid", int'(u_if.rx_valid), 0);
        check("abort_frame_err", int'(u_if.frame_err), 0);
        check("abort_rx_busy", int'(u_if.rx_busy), 0);
        return;
      end
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: bench did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int bad_idle;
    int exp_seq[5];
    rx = 1'b1;
    srst_n = 1'b0;
    repeat (3) @(posedge sclk);
    #1;
    check("rst_state", int'(u_if.state), 0);
    check("rst_rx_data", int'(u_if.rx_data), 0);
    check("rst_rx_valid", int'(u_if.rx_valid), 0);
    check("rst_frame_err", int'(u_if.frame_err), 0);
    check("rst_rx_busy", int'(u_if.rx_busy), 0);
    srst_n = 1'b1;

    // Idle line.
    bad_idle = 0;
    repeat (1000) begin
      @(posedge sclk);
      #1;
      if (u_if.state != 4'd0 || u_if.rx_valid || u_if.frame_err) bad_idle++;
    end
    check("idle_activity", bad_idle, 0);

    // Single frame with busy window and state sequence.
    st_log.delete();
    st_log.push_back(int'(u_if.state));
    drive_frame(8'h55, 1'b1, 0, 1'b1);
    repeat (10) @(posedge sclk);
    exp_seq = '{0, 1, 2, 3, 0};
    check("seq_len", st_log.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < st_log.size()) check("seq_state", st_log[i], exp_seq[i]);
    end

    // Back-to-back frames.
    drive_frame(8'hA3, 1'b1, 0, 1'b0);
    drive_frame(8'h00, 1'b1, 0, 1'b0);
    repeat (10) @(posedge sclk);

    // Glitch rejected.
    for (int i = 0; i < 20; i++) begin
      @(posedge sclk);
      #1;
      rx = (i < 4) ? 1'b0 : 1'b1;
      if (i == 4) check("glitch_in_start", int'(u_if.state), 1);
      if (i == 10) check("glitch_still_start", int'(u_if.state), 1);
      if (i == 11) check("glitch_back_idle", int'(u_if.state), 0);
    end
    check("glitch_rx_data", int'(u_if.rx_data), int'(last_good));

    // Framing error, break, recovery.
    drive_frame(8'hFF, 1'b0, 0, 1'b0);
    repeat (40) @(posedge sclk);
    #1;
    check("brk_state", int'(u_if.state), 4);
    check("brk_rx_data", int'(u_if.rx_data), int'(last_good));
    rx = 1'b1;
    repeat (5) @(posedge sclk);
    #1;
    check("brk_recover", int'(u_if.state), 0);
    drive_frame(8'h3C, 1'b1, 0, 1'b0);
    repeat (10) @(posedge sclk);

    // Reset during data bit 4, then a clean frame.
    drive_frame(8'h10, 1'b1, 5 * Div + 8, 1'b0);
    repeat (30) @(posedge sclk);
    #1;
    check("post_abort_state", int'(u_if.state), 0);
    drive_frame(8'h96, 1'b1, 0, 1'b0);
    repeat (20) @(posedge sclk);

    check("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_byte.md
Name: uart_rx_byte

Overview:
- UART receive front end. Turns the raw asynchronous rx line into framed 8N1 bytes, with a one-cycle valid strobe and a framing-error strobe.
- Downstream consumers use its `state` output the same way as the existing rx state-machine monitor.
- Sits between the board rx pin and the byte consumer (loopback/TX path or register logic). One instance per UART channel.

Parameters:
- BAUD_DIV, 434, sclk cycles per bit (50 MHz / 115200). Legal range 4..65535.

Ports:
- sclk  in  1  system clock.
- srst_n  in  1  reset, synchronous, active-low.
- rx  in  1  raw asynchronous serial line, idle high.
- rx_data  out  8  last correctly framed byte, LSB received first.
- rx_valid  out  1  one-cycle strobe: rx_data updated this cycle.
- frame_err  out  1  one-cycle strobe: stop bit sampled low.
- rx_busy  out  1  high whenever state != IDLE.
- state  out  4  current FSM state code (debug/monitor).

Behaviour:
- Clocking and reset:
  - One clock (sclk). Reset is synchronous, active-low (srst_n), sampled on the sclk rising edge.
  - Reset values: rx_data=0x00, rx_valid=0, frame_err=0, rx_busy=0, state=IDLE (0).
  - The synchronizer flops and the rx_prev flop reset to 1, so no false edge is seen after reset.
- Input conditioning:
  - 2-flop synchronizer rx -> rx_s, plus rx_prev = rx_s delayed one cycle.
  - Falling edge = rx_prev & ~rx_s.
- Counters:
  - baud_cnt is 16 bits.
  - bit_idx is 3 bits.
  - shift is an 8-bit register, shifted right with the new bit entering bit 7.
- States and codes:
  - IDLE (0): on a falling edge -> START; baud_cnt=0.
  - START (1): baud_cnt increments. When baud_cnt == BAUD_DIV/2-1 (integer division), sample rx_s:
    - rx_s=0 -> DATA, baud_cnt=0, bit_idx=0.
    - rx_s=1 -> IDLE, no strobe (glitch reject).
  - DATA (2): when baud_cnt == BAUD_DIV-1:
    - shift = {rx_s, shift[7:1]}, baud_cnt=0.
    - If bit_idx==7 -> STOP, else bit_idx+1.
    - Otherwise baud_cnt increments.
  - STOP (3): when baud_cnt == BAUD_DIV-1, sample rx_s:
    - 1 -> rx_data=shift, rx_valid=1 for the next cycle only, -> IDLE.
    - 0 -> frame_err=1 for the next cycle only, rx_data unchanged, -> BRK.
  - BRK (4): stay until rx_s==1, then -> IDLE. Breaks or a stuck-low line produce exactly one frame_err.
  - Codes 5..15 are unreachable and recover to IDLE on the next cycle.
- Timing:
  - Let T0 be the edge at which the falling edge is detected.
  - Start-bit check at T0+BAUD_DIV/2.
  - Data bit k (0..7) sampled at T0+BAUD_DIV/2+(k+1)*BAUD_DIV.
  - Stop bit sampled at T0+BAUD_DIV/2+9*BAUD_DIV. rx_valid/frame_err are high in the cycle after.
  - The rx pin to T0 delay is 3 cycles (synchronizer plus edge detect).
- Back-to-back frames:
  - Return to IDLE happens mid stop bit.
  - A start edge arriving anywhere after that is accepted; no idle gap is required beyond the stop bit.
- No handshake or buffering:
  - The consumer must take rx_data when rx_valid is asserted.
  - rx_data holds its value until the next good frame.
  - rx_valid and frame_err are never high together.
- Reset mid-frame: next cycle is IDLE with all outputs at reset values. The partial frame is discarded, with no strobe.

Test Plan:
- Setup for all scenarios:
  - BAUD_DIV=16, sclk period 20 ns.
  - 8N1 frames driven at 16 clocks/bit, start edge on a clock edge.
- Frame 0x55 -> exactly one rx_valid pulse, 1 cycle wide, at 8+9*16+1 cycles after T0, with rx_data=0x55. rx_busy is high from T0 until the stop sample. The state sequence is 0,1,2,3,0.
- Frames 0xA3 then 0x00 back-to-back (next start immediately after the stop bit) -> two rx_valid pulses, rx_data 0xA3 then 0x00, and no frame_err.
- rx low for 4 cycles, then high -> state visits 1 and returns to 0 at T0+8. No rx_valid, no frame_err, rx_data unchanged.
- Frame 0xFF with stop bit driven low, line held low for 40 more cycles, then high:
  - One frame_err pulse; rx_valid stays 0; rx_data keeps its previous value.
  - state=4 until the line goes high, then 0.
  - A following 0x3C frame is received correctly.
- srst_n low for 1 cycle in the middle of data bit 4 of a frame -> next cycle state=0 with all outputs at reset values, and no strobe for that frame.
- Idle line high for 1000 cycles after reset -> state stays 0; rx_valid and frame_err are never asserted.
